// File: rtl/kronos_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one req/ack memory bus.
// Optional KRONOS_ARB_ROUND_ROBIN_EN replaces fixed data priority plus starvation counter with round-robin.
module kronos_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_ack,
    output logic [31:0] instr_data,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] data_rd_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   pick_data;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef KRONOS_ARB_ROUND_ROBIN_EN
    // last_owner_q: 1 = data served last, 0 = instruction served last
    logic last_owner_q, last_owner_d;

    assign pick_data = data_req && (!instr_req || !last_owner_q);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            last_owner_q <= 1'b1;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (state_q == IDLE) begin
            if (state_d == GNT_D) begin
                last_owner_d = 1'b1;
            end else if (state_d == GNT_I) begin
                last_owner_d = 1'b0;
            end
        end
    end
`else
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starved;

    assign starved   = instr_req && (cnt_q == CNT_W'(STARVE_LIMIT));
    assign pick_data = data_req && !starved;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counts data grants that bypassed a waiting fetch; saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (!instr_req || state_d == GNT_I) begin
                cnt_d = '0;
            end else if (state_d == GNT_D && cnt_q != CNT_W'(STARVE_LIMIT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_data) begin
                    state_d = GNT_D;
                end else if (instr_req) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr     = '0;
        mem_wr_data  = '0;
        mem_mask     = '0;
        mem_wr_en    = 1'b0;
        mem_req      = 1'b0;
        instr_ack    = 1'b0;
        instr_data   = '0;
        data_ack     = 1'b0;
        data_rd_data = '0;
        case (state_q)
            GNT_I: begin
                mem_req    = 1'b1;
                mem_addr   = instr_addr;
                mem_mask   = 4'hF;
                instr_ack  = mem_ack;
                instr_data = mem_ack ? mem_rd_data : '0;
            end
            GNT_D: begin
                mem_req      = 1'b1;
                mem_addr     = data_addr;
                mem_wr_data  = data_wr_data;
                mem_mask     = data_mask;
                mem_wr_en    = data_wr_en;
                data_ack     = mem_ack;
                data_rd_data = mem_ack ? mem_rd_data : '0;
            end
            default: ;
        endcase
    end

    assign grant = state_q;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Directed-vector bench for kronos_mem_arbiter: fetch, store, contention, wait states, async reset.
module tb_kronos_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic        instr_ack;
    logic [31:0] instr_data;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic        data_ack;
    logic [31:0] data_rd_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_mask;
    logic        mem_wr_en;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rd_data;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kronos_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk          (clk),
        .rstz         (rstz),
        .instr_addr   (instr_addr),
        .instr_req    (instr_req),
        .instr_ack    (instr_ack),
        .instr_data   (instr_data),
        .data_addr    (data_addr),
        .data_wr_data (data_wr_data),
        .data_mask    (data_mask),
        .data_wr_en   (data_wr_en),
        .data_req     (data_req),
        .data_ack     (data_ack),
        .data_rd_data (data_rd_data),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_mask     (mem_mask),
        .mem_wr_en    (mem_wr_en),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_rd_data  (mem_rd_data),
        .grant        (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_seq [10];

    initial begin
`ifdef KRONOS_ARB_ROUND_ROBIN_EN
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
`endif
        rstz = 1'b0;
        instr_addr = '0; instr_req = 1'b0;
        data_addr = '0; data_wr_data = '0; data_mask = '0; data_wr_en = 1'b0; data_req = 1'b0;
        mem_ack = 1'b0; mem_rd_data = '0;

        // Reset state
        step();
        step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_instr_ack", 32'(instr_ack), 32'h0);
        chk("rst_data_ack", 32'(data_ack), 32'h0);
        rstz = 1'b1;
        step();

        // Single fetch
        instr_req = 1'b1; instr_addr = 32'h100; mem_rd_data = 32'h13;
        #1;
        chk("fetch_idle_mem_req", 32'(mem_req), 32'h0);
        chk("fetch_idle_mem_addr", mem_addr, 32'h0);
        step();
        $display("txn fetch grant cycle addr=%h", mem_addr);
        chk("fetch_mem_req", 32'(mem_req), 32'h1);
        chk("fetch_grant", 32'(grant), 32'h1);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_wr_en", 32'(mem_wr_en), 32'h0);
        chk("fetch_mask", 32'(mem_mask), 32'hF);
        chk("fetch_wr_data", mem_wr_data, 32'h0);
        chk("fetch_ack_early", 32'(instr_ack), 32'h0);
        chk("fetch_data_early", instr_data, 32'h0);
        step();
        mem_ack = 1'b1;
        #1;
        chk("fetch_ack", 32'(instr_ack), 32'h1);
        chk("fetch_data", instr_data, 32'h13);
        chk("fetch_data_ack", 32'(data_ack), 32'h0);
        step();
        instr_req = 1'b0; mem_ack = 1'b0;
        #1;
        chk("fetch_done_grant", 32'(grant), 32'h0);
        chk("fetch_done_ack", 32'(instr_ack), 32'h0);

        // Store
        data_req = 1'b1; data_addr = 32'h80; data_wr_data = 32'h00080AAA;
        data_mask = 4'h3; data_wr_en = 1'b1;
        step();
        mem_ack = 1'b1;
        #1;
        $display("txn store addr=%h wdata=%h mask=%h", mem_addr, mem_wr_data, mem_mask);
        chk("store_grant", 32'(grant), 32'h2);
        chk("store_mem_addr", mem_addr, 32'h80);
        chk("store_wr_data", mem_wr_data, 32'h00080AAA);
        chk("store_mask", 32'(mem_mask), 32'h3);
        chk("store_wr_en", 32'(mem_wr_en), 32'h1);
        chk("store_data_ack", 32'(data_ack), 32'h1);
        chk("store_instr_ack", 32'(instr_ack), 32'h0);
        step();
        data_req = 1'b0; data_wr_en = 1'b0; mem_ack = 1'b0;
        #1;
        chk("store_ack_pulse", 32'(data_ack), 32'h0);
        chk("store_idle_grant", 32'(grant), 32'h0);

        // Contention with immediate ack
        instr_req = 1'b1; instr_addr = 32'h200;
        data_req = 1'b1; data_addr = 32'h300; data_mask = 4'hF;
        mem_ack = 1'b1; mem_rd_data = 32'h5555AAAA;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("cont_idle_%0d", i), 32'(grant), 32'h0);
            chk($sformatf("cont_idle_ack_%0d", i), 32'({instr_ack, data_ack}), 32'h0);
            step();
            $display("txn contention %0d grant=%b", i, grant);
            chk($sformatf("cont_grant_%0d", i), 32'(grant), 32'(exp_seq[i]));
            chk($sformatf("cont_ack_%0d", i), 32'({data_ack, instr_ack}), 32'(exp_seq[i]));
            step();
        end
        instr_req = 1'b0; data_req = 1'b0; mem_ack = 1'b0;
        step();

        // Wait-state load
        data_req = 1'b1; data_addr = 32'h40; data_wr_en = 1'b0; data_mask = 4'hF;
        mem_rd_data = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ws_mem_req_%0d", i), 32'(mem_req), 32'h1);
            chk($sformatf("ws_addr_%0d", i), mem_addr, 32'h40);
            chk($sformatf("ws_rd_data_%0d", i), data_rd_data, 32'h0);
            chk($sformatf("ws_ack_%0d", i), 32'(data_ack), 32'h0);
        end
        step();
        mem_ack = 1'b1;
        #1;
        $display("txn load addr=%h rdata=%h", mem_addr, data_rd_data);
        chk("ws_final_req", 32'(mem_req), 32'h1);
        chk("ws_final_addr", mem_addr, 32'h40);
        chk("ws_final_rd_data", data_rd_data, 32'hDEADBEEF);
        chk("ws_final_ack", 32'(data_ack), 32'h1);
        step();
        data_req = 1'b0; mem_ack = 1'b0;
        #1;
        chk("ws_after_rd_data", data_rd_data, 32'h0);
        chk("ws_after_req", 32'(mem_req), 32'h0);

        // Reset mid-transaction
        data_req = 1'b1; data_addr = 32'h500; data_wr_en = 1'b1; data_wr_data = 32'h1234;
        step();
        chk("rm_grant_pre", 32'(grant), 32'h2);
        #2;
        rstz = 1'b0;
        #1;
        chk("rm_async_req", 32'(mem_req), 32'h0);
        chk("rm_async_grant", 32'(grant), 32'h0);
        data_req = 1'b0; data_wr_en = 1'b0;
        instr_req = 1'b1; instr_addr = 32'h600; mem_ack = 1'b1;
        step();
        chk("rm_late_iack", 32'(instr_ack), 32'h0);
        chk("rm_late_dack", 32'(data_ack), 32'h0);
        rstz = 1'b1; mem_ack = 1'b0;
        #1;
        chk("rm_release_grant", 32'(grant), 32'h0);
        step();
        $display("txn post-reset grant=%b addr=%h", grant, mem_addr);
        chk("rm_fetch_grant", 32'(grant), 32'h1);
        chk("rm_fetch_addr", mem_addr, 32'h600);
        mem_ack = 1'b1;
        step();
        instr_req = 1'b0; mem_ack = 1'b0;
        #1;
        chk("rm_end_grant", 32'(grant), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kronos_mem_arbiter.md
Name: kronos_mem_arbiter

Overview:
Shares one single-ported memory bus between the Kronos instruction-fetch port and load/store port. It sits between kronos_core and the memory or system bus, and uses the same req/ack handshake on every side. Data accesses have priority by default. A starvation counter guarantees that fetch eventually makes progress.

Parameters:
STARVE_LIMIT, 4, number of consecutive data grants while instr_req is waiting; after this many, the next grant is forced to instruction.
CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
clk  input  1  clock; all state updates on the rising edge
rstz  input  1  asynchronous reset, active-low
instr_addr  input  32  fetch address from the core
instr_req  input  1  fetch request; held high until instr_ack
instr_ack  output  1  fetch complete; instr_data is valid in this cycle
instr_data  output  32  fetch data
data_addr  input  32  load/store address
data_wr_data  input  32  store data
data_mask  input  4  byte-lane mask
data_wr_en  input  1  1 = store, 0 = load
data_req  input  1  load/store request; held high until data_ack
data_ack  output  1  load/store complete
data_rd_data  output  32  load data
mem_addr  output  32  shared bus address
mem_wr_data  output  32  shared bus write data
mem_mask  output  4  shared bus byte mask
mem_wr_en  output  1  shared bus write enable
mem_req  output  1  shared bus request
mem_ack  input  1  shared bus ack; read data valid in the same cycle
mem_rd_data  input  32  shared bus read data
grant  output  2  current owner: 00 none, 01 instruction, 10 data

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. State is registered; reset forces IDLE.
- Reset values: grant=00, mem_req=0, instr_ack=0, data_ack=0, starvation counter=0.
- Reset mid-transaction drops to IDLE immediately. A mem_ack that arrives after reset is ignored.
- Arbitration happens in IDLE only:
  - data_req and not starved -> GNT_D.
  - else instr_req -> GNT_I.
  - starved means counter==STARVE_LIMIT and instr_req=1.
- mem_req=1 exactly while state is GNT_I or GNT_D. It is asserted one cycle after both requests are sampled.
- Mux while granted: mem_addr, mem_wr_data, mem_mask and mem_wr_en come combinationally from the owner's inputs.
- In GNT_I: mem_wr_en=0, mem_mask=4'hF, mem_wr_data=0.
- In IDLE: all mem_* outputs are 0.
- Acks: instr_ack = (state==GNT_I) & mem_ack, and data_ack = (state==GNT_D) & mem_ack. Both are combinational, with zero added latency.
- Read data: instr_data and data_rd_data pass mem_rd_data through. Each is qualified by its own ack and is 0 otherwise.
- On mem_ack the FSM returns to IDLE. Minimum cost is 2 cycles per transfer: 1 grant cycle plus 1 idle/arbitrate cycle.
- A mem_ack seen in IDLE is ignored.
- Starvation counter:
  - Increments on each data grant made while instr_req=1.
  - Clears on any instruction grant, or when instr_req=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- Simultaneous requests in IDLE: data wins unless starved.
- Requests must stay stable while pending. A request withdrawn before its ack is a protocol violation, and the FSM still waits for mem_ack.
- No timeout: a missing mem_ack stalls the arbiter indefinitely.

Optional Feature:
Macro KRONOS_ARB_ROUND_ROBIN_EN.
- Defined: the starvation counter is removed and STARVE_LIMIT is ignored. A registered last_owner bit records the previous owner. On simultaneous requests, the requester that was not last served wins; reset sets last_owner to data, so instruction wins first.
- Undefined: fixed data priority with the starvation limit described above.

Test Plan:
- Single fetch: instr_req=1, instr_addr=0x100, mem_ack one cycle after mem_req, mem_rd_data=0x00000013 -> mem_req high 1 cycle later, mem_addr=0x100, mem_wr_en=0, instr_ack=1 with instr_data=0x13, grant returns to 00.
- Store: data_req=1, data_addr=0x80, data_wr_data=0x00080AAA, data_mask=0x3, data_wr_en=1 -> mem_* mirror the inputs exactly, data_ack pulses for 1 cycle on mem_ack, instr_ack stays 0.
- Contention: both requests held continuously, mem_ack immediate -> grant sequence D,D,D,D,I,D,D,D,D,I (STARVE_LIMIT=4). With KRONOS_ARB_ROUND_ROBIN_EN the sequence is I,D,I,D.
- Wait states: data load, mem_ack delayed 5 cycles, mem_rd_data=0xDEADBEEF -> mem_req held 5 cycles with stable address, data_rd_data=0xDEADBEEF only in the ack cycle.
- Reset mid-operation: rstz low during GNT_D before mem_ack -> mem_req=0 and grant=00 asynchronously. A late mem_ack produces no ack. After release, a pending instr_req is served first.
